// File: rtl/fpdiv_pkg.sv
// Shared types and constants for the FP32 divider result buffer.
// Flag bit positions, the FIFO entry layout and the exponent all-ones value.
package fpdiv_pkg;

    localparam int FLG_W    = 5;
    localparam int FLG_OVF  = 4;
    localparam int FLG_UNF  = 3;
    localparam int FLG_NAN  = 2;
    localparam int FLG_INF  = 1;
    localparam int FLG_ZERO = 0;

    localparam logic [7:0] EXP_ALL1 = 8'hFF;

    typedef struct packed {
        logic [31:0]      res;
        logic [FLG_W-1:0] flg;
    } fpdiv_entry_t;

endpackage

// File: rtl/fpdiv_classify.sv
// Combinational classifier: FP32 word plus divider ovf/unf into the
// five-bit flag vector {ovf,unf,nan,inf,zero}.
module fpdiv_classify
    import fpdiv_pkg::*;
(
    input  logic [31:0]      i_word,
    input  logic             i_ovf,
    input  logic             i_unf,
    output logic [FLG_W-1:0] o_flg
);

    logic [7:0]  w_exp;
    logic [22:0] w_man;
    logic        w_exp_max;
    logic        w_exp_min;
    logic        w_man_zero;

    assign w_exp      = i_word[30:23];
    assign w_man      = i_word[22:0];
    assign w_exp_max  = (w_exp == EXP_ALL1);
    assign w_exp_min  = (w_exp == 8'h00);
    assign w_man_zero = (w_man == 23'h0);

    always_comb begin
        o_flg           = '0;
        o_flg[FLG_OVF]  = i_ovf;
        o_flg[FLG_UNF]  = i_unf;
        o_flg[FLG_NAN]  = w_exp_max & ~w_man_zero;
        o_flg[FLG_INF]  = w_exp_max & w_man_zero;
        o_flg[FLG_ZERO] = w_exp_min & w_man_zero;
    end

endmodule

// File: rtl/fpdiv_result_buffer.sv
// Result FIFO behind the FP32 divider with per-entry classification flags.
// Define FPDIV_STICKY_FLAGS_EN to add sticky_clr / sticky_flags status.
module fpdiv_result_buffer
    import fpdiv_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_result,
    input  logic             in_overflow,
    input  logic             in_underflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [FLG_W-1:0] out_flags,
    output logic [CNT_W-1:0] count
`ifdef FPDIV_STICKY_FLAGS_EN
   ,input  logic             sticky_clr,
    output logic [FLG_W-1:0] sticky_flags
`endif
);

    localparam int               PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    fpdiv_entry_t     r_mem [DEPTH];

    logic [FLG_W-1:0] w_flg;
    fpdiv_entry_t     w_entry;
    fpdiv_entry_t     w_head;
    logic [PTR_W-1:0] w_last_ptr;
    logic             w_push;
    logic             w_pop;

    fpdiv_classify u_classify (
        .i_word (in_result),
        .i_ovf  (in_overflow),
        .i_unf  (in_underflow),
        .o_flg  (w_flg)
    );

    assign w_entry.res = in_result;
    assign w_entry.flg = w_flg;

    assign in_ready  = (r_count != FULL);
    assign out_valid = (r_count != '0);
    assign count     = r_count;

    assign w_push = in_valid & in_ready;
    assign w_pop  = out_valid & out_ready;

    // The slot behind rd_ptr is only rewritten after a full lap, so when
    // empty it still holds the last entry popped (or the reset zero).
    assign w_last_ptr = r_rd_ptr - 1'b1;
    assign w_head     = out_valid ? r_mem[r_rd_ptr] : r_mem[w_last_ptr];

    assign out_result = w_head.res;
    assign out_flags  = w_head.flg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_entry;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef FPDIV_STICKY_FLAGS_EN
    logic [FLG_W-1:0] r_sticky;

    // A push in the clear cycle leaves exactly that entry's flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky <= '0;
        end else if (w_push) begin
            r_sticky <= (sticky_clr ? '0 : r_sticky) | w_flg;
        end else if (sticky_clr) begin
            r_sticky <= '0;
        end
    end

    assign sticky_flags = r_sticky;
`endif

endmodule

// File: tb/tb_fpdiv_result_buffer.sv
// Self-checking bench for fpdiv_result_buffer: classification table,
// directed FIFO corner sequences and a randomized run against a queue model.
module tb_fpdiv_result_buffer;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic        in_overflow;
    logic        in_underflow;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_flags;
    logic [2:0]  count;
    logic        sticky_clr;
    logic [4:0]  sticky_flags;

    int errors = 0;
    int checks = 0;

    fpdiv_result_buffer #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_overflow  (in_overflow),
        .in_underflow (in_underflow),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_flags    (out_flags),
        .count        (count)
`ifdef FPDIV_STICKY_FLAGS_EN
       ,.sticky_clr   (sticky_clr),
        .sticky_flags (sticky_flags)
`endif
    );

`ifndef FPDIV_STICKY_FLAGS_EN
    assign sticky_flags = 5'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a queue of {result, flags}, the last popped head,
    // and the sticky accumulator.
    typedef struct {
        logic [31:0] res;
        logic [4:0]  flg;
    } ent_t;

    ent_t        q[$];
    ent_t        last;
    logic [4:0]  m_sticky;

    function automatic logic [4:0] classify(logic [31:0] w, logic ovf, logic unf);
        int unsigned e;
        int unsigned m;
        logic nan, inf, zero;
        e    = (w >> 23) & 32'hFF;
        m    = w & 32'h7F_FFFF;
        nan  = (e == 255) && (m != 0);
        inf  = (e == 255) && (m == 0);
        zero = (e == 0) && (m == 0);
        return {ovf, unf, nan, inf, zero};
    endfunction

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        q.delete();
        last.res = 32'h0;
        last.flg = 5'h0;
        m_sticky = 5'h0;
    endfunction

    function automatic void check_outputs();
        ent_t h;
        h = (q.size() != 0) ? q[0] : last;
        chk("in_ready",  32'(in_ready),  32'(q.size() != DEPTH));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("count",     32'(count),     32'(q.size()));
        chk("out_result", out_result,    h.res);
        chk("out_flags", 32'(out_flags), 32'(h.flg));
`ifdef FPDIV_STICKY_FLAGS_EN
        chk("sticky", 32'(sticky_flags), 32'(m_sticky));
`else
        chk("sticky_off", 32'(sticky_flags), 32'h0);
`endif
    endfunction

    function automatic void model_update();
        bit   push, pop;
        ent_t e;
        if (!rst_n) begin
            model_reset();
            return;
        end
        push = in_valid && (q.size() != DEPTH);
        pop  = out_ready && (q.size() != 0);
        e.res = in_result;
        e.flg = classify(in_result, in_overflow, in_underflow);
        if (pop) begin
            last = q.pop_front();
        end
        if (push) begin
            q.push_back(e);
            m_sticky = (sticky_clr ? 5'h0 : m_sticky) | e.flg;
        end else if (sticky_clr) begin
            m_sticky = 5'h0;
        end
    endfunction

    task automatic step();
        check_outputs();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive(logic v, logic [31:0] r, logic o, logic u);
        in_valid     = v;
        in_result    = r;
        in_overflow  = o;
        in_underflow = u;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) step();
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        logic [4:0]  flg;
    } vec_t;

    vec_t       tbl[9];
    logic [4:0] exp3[3];

    initial begin
        tbl[0] = '{32'h3F0BA2E9, 1'b0, 1'b0, 5'b00000};
        tbl[1] = '{32'h7F800000, 1'b1, 1'b0, 5'b10010};
        tbl[2] = '{32'h7FC00000, 1'b0, 1'b0, 5'b00100};
        tbl[3] = '{32'h00000000, 1'b0, 1'b1, 5'b01001};
        tbl[4] = '{32'h80000000, 1'b0, 1'b0, 5'b00001};
        tbl[5] = '{32'hFF800000, 1'b0, 1'b0, 5'b00010};
        tbl[6] = '{32'h7F800001, 1'b0, 1'b0, 5'b00100};
        tbl[7] = '{32'h00000001, 1'b0, 1'b0, 5'b00000};
        tbl[8] = '{32'h7F7FFFFF, 1'b1, 1'b1, 5'b11000};
        exp3[0] = 5'b10010;
        exp3[1] = 5'b00100;
        exp3[2] = 5'b01001;

        // Reset with in_valid high
        rst_n      = 1'b0;
        out_ready  = 1'b0;
        sticky_clr = 1'b0;
        drive(1'b1, 32'h12345678, 1'b1, 1'b1);
        model_reset();
        #1;
        chk("rst_in_ready",  32'(in_ready),  32'h1);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_count",     32'(count),     32'h0);
        chk("rst_out_flags", 32'(out_flags), 32'h0);
        step();
        step();
        rst_n = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        step();

        // Single push latency
        drive(1'b1, 32'h3F0BA2E9, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("lat_out_valid", 32'(out_valid), 32'h1);
        chk("lat_result",    out_result,     32'h3F0BA2E9);
        chk("lat_flags",     32'(out_flags), 32'h0);
        drain();
        chk("empty_holds_last", out_result, 32'h3F0BA2E9);

        // Classification table
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, tbl[i].res, tbl[i].ovf, tbl[i].unf);
            step();
            drive(1'b0, 32'h0, 1'b0, 1'b0);
            chk($sformatf("tbl%0d_result", i), out_result, tbl[i].res);
            chk($sformatf("tbl%0d_flags", i), 32'(out_flags), 32'(tbl[i].flg));
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end

        // Three pushes held, then drained in order
        drive(1'b1, 32'h7F800000, 1'b1, 1'b0); step();
        drive(1'b1, 32'h7FC00000, 1'b0, 1'b0); step();
        drive(1'b1, 32'h00000000, 1'b0, 1'b1); step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("three_count", 32'(count), 32'h3);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("drain%0d_flags", i), 32'(out_flags), 32'(exp3[i]));
            step();
        end
        out_ready = 1'b0;
        chk("drained_valid", 32'(out_valid), 32'h0);

        // Fill, refused push while full, then push+pop across wrap
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 32'hA000_0000 + 32'(i), 1'b0, 1'b0);
            step();
        end
        chk("full_in_ready", 32'(in_ready), 32'h0);
        chk("full_count",    32'(count),    32'(DEPTH));
        drive(1'b1, 32'hDEADBEEF, 1'b1, 1'b1);
        step();
        chk("full_hold_count", 32'(count), 32'(DEPTH));
        chk("full_head",       out_result, 32'hA000_0000);
        out_ready = 1'b1;
        for (int i = 0; i < 2 * DEPTH; i++) begin
            drive(1'b1, 32'hB000_0000 + 32'(i), 1'b0, 1'b0);
            step();
        end
        drain();

`ifdef FPDIV_STICKY_FLAGS_EN
        sticky_clr = 1'b1;
        step();
        sticky_clr = 1'b0;
        out_ready  = 1'b1;
        drive(1'b1, 32'hFF800000, 1'b0, 1'b0);
        step();
        chk("sticky_inf", 32'(sticky_flags), 32'h02);
        sticky_clr = 1'b1;
        drive(1'b1, 32'h00000000, 1'b0, 1'b0);
        step();
        sticky_clr = 1'b0;
        chk("sticky_clr_push", 32'(sticky_flags), 32'h01);
        drain();
`endif

        // Asynchronous reset mid-stream
        drive(1'b1, 32'h40490FDB, 1'b0, 1'b0); step();
        drive(1'b1, 32'hC0000000, 1'b0, 1'b0); step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("pre_rst_count", 32'(count), 32'h2);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_count",     32'(count),     32'h0);
        chk("async_out_valid", 32'(out_valid), 32'h0);
        chk("async_result",    out_result,     32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [31:0] r;
            logic [31:0] m;
            r = $urandom;
            m = $urandom;
            m = (m & 32'h7F_FFFF) | 32'h1;
            case ($urandom_range(0, 5))
                0: r = {r[31], 8'hFF, 23'h0};
                1: r = {r[31], 8'hFF, m[22:0]};
                2: r = {r[31], 31'h0};
                3: r = {r[31], 8'h00, m[22:0]};
                default: ;
            endcase
            drive($urandom_range(0, 3) != 0, r,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
            out_ready  = $urandom_range(0, 2) != 0;
            sticky_clr = $urandom_range(0, 9) == 0;
            step();
        end
        sticky_clr = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
